// File: rtl/uart_fifo_param.sv
// Parametrised FIFO for the UART transmit/receive paths: data plus per-entry error tag,
// live occupancy count, trigger threshold, flush, and an error-in-FIFO flag.
module uart_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TAG_W  = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [DATA_W-1:0] din,
    input  logic [TAG_W-1:0]  tag_in,
    output logic [DATA_W-1:0] dout,
    output logic [TAG_W-1:0]  tag_out,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overrun,
    output logic              underrun,
    input  logic [CNT_W-1:0]  threshold,
    output logic              thre_trigger,
    output logic              err_in_fifo
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = TAG_W + DATA_W;
    localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;

    logic             push_req, pop_req;
    logic             wr, rd;
    logic             err_inc, err_dec;
    logic [ENT_W-1:0] head;

    // Status decoded purely from the occupancy count.
    always_comb begin
        full  = (count_q == DepthCnt);
        empty = (count_q == '0);
        count = count_q;
    end

    // First-word fall-through head; zero while empty so stale memory never leaks out.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        dout    = '0;
        tag_out = '0;
        if (!empty) begin
            dout    = head[DATA_W-1:0];
            tag_out = head[ENT_W-1:DATA_W];
        end
    end

    always_comb begin
        push_req = en & push_in;
        pop_req  = en & pop_in;
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        wr       = push_req & (~full | pop_in);
        rd       = pop_req & ~empty;
        err_inc  = wr & (tag_in != '0);
        err_dec  = rd & (tag_out != '0);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (wr) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
            end

            case ({wr, rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            case ({err_inc, err_dec})
                2'b10:   err_cnt_d = err_cnt_q + CNT_W'(1);
                2'b01:   err_cnt_d = err_cnt_q - CNT_W'(1);
                default: err_cnt_d = err_cnt_q;
            endcase

            overrun_d  = push_req & full & ~pop_in;
            underrun_d = pop_req & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr) begin
            mem_q[wr_ptr_q] <= {tag_in, din};
        end
    end

    always_comb begin
        overrun      = overrun_q;
        underrun     = underrun_q;
        err_in_fifo  = (err_cnt_q != '0);
        // A threshold above DEPTH can never be met because count saturates at DEPTH.
        thre_trigger = (threshold != '0) && (count_q >= threshold);
    end

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
Parametrised FIFO for the 16550A transmit and receive paths. It generalises the fixed 16x8 fifo_top in four ways: configurable data width and depth, a live occupancy count, and a per-entry error tag (parity/framing/break) stored alongside each data word. It also adds a synchronous flush and an error-in-FIFO flag for LSR bit 7. It sits between the UART shift-register logic and the register-interface read/write path.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of entries; any value >= 2 (not required to be a power of 2)
TAG_W, 3, per-entry error tag width; a tag of 0 means no error
CNT_W, $clog2(DEPTH+1), derived localparam, width of count and threshold

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
en  in  1  FIFO enable; when 0, push_in and pop_in are ignored
flush  in  1  synchronous clear of contents (FCR reset bit)
push_in  in  1  write request
pop_in  in  1  read request
din  in  DATA_W  write data
tag_in  in  TAG_W  error tag written with din
dout  out  DATA_W  head-entry data (first-word fall-through)
tag_out  out  TAG_W  head-entry tag
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  CNT_W  number of stored entries
overrun  out  1  one-cycle pulse: push was rejected
underrun  out  1  one-cycle pulse: pop was rejected
threshold  in  CNT_W  trigger level
thre_trigger  out  1  occupancy has reached threshold
err_in_fifo  out  1  at least one stored entry has a nonzero tag

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, err_cnt=0, overrun=0, underrun=0. After reset: empty=1, full=0, thre_trigger=0, err_in_fifo=0, dout=0, tag_out=0. Memory contents are not reset.
- Priority per edge: rst > flush > push/pop. flush resets the pointers, count and err_cnt exactly as rst does, and drops any push or pop in the same cycle without raising flags.
- Effective operations: wr = en & push_in & (!full | pop_in); rd = en & pop_in & !empty.
- Write: mem[wr_ptr] <= {tag_in, din}; wr_ptr advances, and wraps from DEPTH-1 to 0.
- Read: rd_ptr advances with the same wrap rule.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Push+pop when full: both succeed, count stays DEPTH, no overrun.
- Push+pop when empty: the push succeeds, the pop is rejected with an underrun pulse, and count becomes 1.
- overrun: registered. Asserted for one cycle after an edge where en & push_in & full & !pop_in. The word is dropped and contents are unchanged.
- underrun: registered. Asserted for one cycle after an edge where en & pop_in & empty. Pointers are unchanged.
- en=0: no state change other than flush or rst; no flags are raised.
- dout/tag_out: combinational from mem[rd_ptr] when !empty; forced to 0 when empty. A word written at edge N is visible at dout after edge N. A pop at edge N presents the next entry after edge N.
- err_cnt (width CNT_W): +1 when a write carries a nonzero tag_in; -1 when a read removes an entry with a nonzero tag_out; both in the same cycle leave it unchanged. err_in_fifo = (err_cnt != 0).
- thre_trigger = (threshold != 0) & (count >= threshold). A threshold above DEPTH never triggers. The output is combinational from registered state, so there is no extra latency beyond count.
- full and empty are decoded from count; no extra pointer-equality bit is used.
- A reset asserted mid-stream overrides a simultaneous push or pop in that cycle.

Test Plan:
1. Reset for 5 cycles, then push 20 random bytes with en=1, threshold=10, DEPTH=16 -> count reaches 16 after the 16th push; full=1; overrun pulses on pushes 17-20; thre_trigger rises on the edge where count goes 9->10; the first 16 bytes are retained.
2. Pop 20 times from the full state -> dout sequence matches the first 16 pushed bytes in order; empty=1 after the 16th pop; underrun pulses on pops 17-20; dout=0 when empty.
3. Fill to full, then push+pop together for 5 cycles with distinct data -> count stays 16, no overrun, order preserved across pointer wrap.
4. Push 0x11 (tag 0), 0x22 (tag 3'b010), 0x33 (tag 0) -> err_in_fifo=1. Pop twice -> after the second pop (0x22 removed) err_in_fifo=0 and dout=0x33.
5. Hold en=0 with push_in=1 and pop_in=1 for 4 cycles -> count, pointers and flags unchanged. Then, with count=7, assert flush together with push_in -> count=0, empty=1, err_in_fifo=0, no overrun.
6. Rebuild with DATA_W=9, DEPTH=5 and push 7 words -> full at 5, 2 overrun pulses. Pop all -> correct order across the non-power-of-2 wrap. Assert rst mid-stream -> count=0 on the next cycle.
